zipomem: RTL and testbench

Single-port, 64-bit-wide synchronous memory responder for the zipocpu bus. It answers the CPU's `rw`/`addr`/`write` requests with registered `read` data, one request per clock. It optionally clears its array after reset through a sequencing state machine and flags any access outside its window with a sticky fault bit. It sits directly on the CPU bus, as instruction/data memory.

---
 rtl/zipomem.sv | 97 +++++++++
 tb/tb_zipomem.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/zipomem.sv
// zipomem: single-port 64-bit synchronous memory responder for the zipocpu bus.
//   Optional post-reset array clear is compiled in with `define ZIPOMEM_CLEAR_EN.
//   Ports:
//     clk   in   system clock
//     rst_n in   asynchronous active-low reset
//     rw    in   1 = write, 0 = read
//     addr  in   64-bit byte address, bits [2:0] ignored
//     write in   64-bit write data
//     read  out  registered read data (write-first echo on writes)
//     ready out  array usable
//     fault out  sticky out-of-window access flag
module zipomem #(
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rw,
  input  logic [63:0] addr,
  input  logic [63:0] write,
  output logic [63:0] read,
  output logic        ready,
  output logic        fault
);
  typedef enum logic [1:0] {S_RESET = 2'd0, S_CLEAR = 2'd1, S_RUN = 2'd2} state_e;
  state_e                  state_q, state_d;
  logic [63:0]             mem [0:(1 << DEPTH_LOG2)-1];
  logic [63:0]             off;
  logic                    in_win;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_wa;
  logic [63:0]             mem_wd;
  logic [63:0]             read_q, read_d;
  logic                    fault_q, fault_d;
  logic                    unused_lsb;
`ifdef ZIPOMEM_CLEAR_EN
  logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
`endif
  // The explicit compare keeps a huge BASE_ADDR from letting a wrapped offset look small.
  assign off        = addr - BASE_ADDR;
  assign in_win     = (addr >= BASE_ADDR) && (off[63:DEPTH_LOG2+3] == '0);
  assign idx        = off[DEPTH_LOG2+2:3];
  assign unused_lsb = ^off[2:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
`ifdef ZIPOMEM_CLEAR_EN
    if (state_q == S_RESET) state_d = S_CLEAR;
    else if (state_q == S_CLEAR && cnt_q == '1) state_d = S_RUN;
`else
    if (state_q == S_RESET) state_d = S_RUN;
`endif
  end
  always_comb begin
    ready   = state_q == S_RUN;
    mem_we  = ready && in_win && rw;
    mem_wa  = idx;
    mem_wd  = write;
    read_d  = (ready && in_win) ? (rw ? write : mem[idx]) : '0;
    fault_d = fault_q | (ready & ~in_win);
`ifdef ZIPOMEM_CLEAR_EN
    cnt_d   = cnt_q;
    // While clearing, the bus is ignored and the port belongs to the sweep counter.
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
      cnt_d  = cnt_q + 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q  <= '0;
      fault_q <= 1'b0;
`ifdef ZIPOMEM_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      read_q  <= read_d;
      fault_q <= fault_d;
`ifdef ZIPOMEM_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  // Array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end
  assign read  = read_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_zipomem.sv
// tb_zipomem: self-checking bench for zipomem (BASE 0x1000, 16 words).
module tb_zipomem;
  localparam logic [63:0] BASE = 64'h1000;
`ifdef ZIPOMEM_CLEAR_EN
  localparam bit CLR       = 1'b1;
  localparam int RDY_EDGES = 17;
`else
  localparam bit CLR       = 1'b0;
  localparam int RDY_EDGES = 1;
`endif
  typedef struct {
    bit          w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] er;
    bit          ef;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rw = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] read;
  logic        ready;
  logic        fault;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mem_m [16];
  bit          fault_m = 1'b0;
  vec_t        tv [10];
  always #5 clk = ~clk;
  zipomem #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .rw(rw), .addr(addr), .write(wdata),
    .read(read), .ready(ready), .fault(fault)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    fault_m = 1'b0;
    if (CLR) foreach (mem_m[i]) mem_m[i] = '0;
  endtask
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (ready) break;
      chk("clear_read", read, 64'h0);
      chk("clear_fault", 64'(fault), 64'h0);
    end
    chk("ready_edges", 64'(n), 64'(RDY_EDGES));
    model_reset();
  endtask
  // Reference: byte-range window test, word = byte offset / 8.
  task automatic step(input bit w, input logic [63:0] a, input logic [63:0] d);
    logic [63:0] off;
    logic [63:0] e;
    @(negedge clk);
    rw = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    off = a - BASE;
    if (a >= BASE && off < 64'd128) begin
      if (w) mem_m[int'(off >> 3)] = d;
      e = mem_m[int'(off >> 3)];
    end else begin
      e = '0;
      fault_m = 1'b1;
    end
    chk(w ? "wr_echo" : "rd_data", read, e);
    chk("fault", 64'(fault), 64'(fault_m));
  endtask
  initial begin
    tv[0] = '{1'b1, 64'h1000, 64'h1111, 64'h1111, 1'b0};
    tv[1] = '{1'b1, 64'h1018, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 1'b0};
    tv[2] = '{1'b0, 64'h1018, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0};
    tv[3] = '{1'b0, 64'h101C, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0};
    tv[4] = '{1'b0, 64'h0FF8, 64'h0, 64'h0, 1'b1};
    tv[5] = '{1'b1, 64'h1080, 64'h5, 64'h0, 1'b1};
    tv[6] = '{1'b0, 64'h1000, 64'h0, 64'h1111, 1'b1};
    tv[7] = '{1'b0, 64'h0, 64'h0, 64'h0, 1'b1};
    tv[8] = '{1'b1, 64'h1078, 64'h77, 64'h77, 1'b1};
    tv[9] = '{1'b0, 64'hFFFFFFFF_FFFFFFF8, 64'h0, 64'h0, 1'b1};
    #12;
    chk("rst_read", read, 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    rw = 1'b1;
    addr = BASE + 64'h18;
    wdata = 64'h1;
    wait_ready();
    if (CLR) for (int i = 0; i < 16; i++) step(1'b0, BASE + 64'(i * 8), 64'h0);
    for (int i = 0; i < 16; i++) step(1'b1, BASE + 64'(i * 8), {$urandom, $urandom});
    for (int i = 0; i < 10; i++) begin
      step(tv[i].w, tv[i].a, tv[i].d);
      chk("tbl_read", read, tv[i].er);
      chk("tbl_fault", 64'(fault), 64'(tv[i].ef));
    end
    step(1'b0, BASE, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_read", read, 64'h0);
    chk("async_ready", 64'(ready), 64'h0);
    chk("async_fault", 64'(fault), 64'h0);
    rw = 1'b0;
    wait_ready();
    step(1'b0, BASE, 64'h0);
    @(negedge clk);
    rw = 1'b1;
    addr = BASE + 64'h8;
    wdata = 64'h9;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 64'(ready), 64'h0);
    chk("mid_read", read, 64'h0);
    chk("mid_fault", 64'(fault), 64'h0);
    if (!CLR) mem_m[1] = 64'h9;
    wait_ready();
    step(1'b0, BASE + 64'h8, 64'h0);
    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [63:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = BASE + 64'($urandom_range(0, 127));
      else if (sel == 7) a = 64'($urandom_range(0, 'hFFF));
      else if (sel == 8) a = BASE + 64'd128 + 64'($urandom_range(0, 1000));
      else               a = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
